pid_pwm_driver: RTL and testbench
=================================

PID_PWM_DRIVER -- requirements
Module: pid_pwm_driver

Interface
REQ-001 SHALL have parameter CNT_W, default 8: PWM counter width.
REQ-002 SHALL have parameter PERIOD, default 100: counts per PWM period, 2..2^CNT_W-1.
REQ-003 SHALL have parameter DT, default 3: dead-time in clocks, 1..15; used only when dead-time is compiled in.
REQ-004 SHALL have port clk, input, 1: the single clock; all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port en, input, 1: run enable.
REQ-007 SHALL have port ctrl_data, input, 16: signed two's-complement control value from the PID stage.
REQ-008 SHALL have port ctrl_valid, input, 1: ctrl_data is valid.
REQ-009 SHALL have port ctrl_ready, output, 1: the block can accept ctrl_data.
REQ-010 SHALL have port pwm_h, output, 1: high-side PWM.
REQ-011 SHALL have port pwm_l, output, 1: low-side PWM.
REQ-012 SHALL have port period_start, output, 1: one-clock pulse at each period start; this is the PID sample trigger.
REQ-013 SHALL have port sat, output, 1: the last accepted value was clipped.

Function
REQ-014 SHALL run counter cnt 0..PERIOD-1 while en=1, wrapping PERIOD-1 -> 0; period_start=1 exactly in cycles where en=1 and cnt==0.
REQ-015 SHALL accept a sample when ctrl_valid && ctrl_ready; ctrl_ready = !pending.
REQ-016 SHALL saturate an accepted sample: below 0 -> 0, above PERIOD -> PERIOD, otherwise unchanged; write it into the shadow register and set pending=1.
REQ-017 SHALL, on the same edge, set sat=1 if the sample was clipped and 0 otherwise; sat holds until the next accept.
REQ-018 SHALL copy shadow into the active duty register and clear pending on the edge where cnt wraps PERIOD-1 -> 0; duty never changes mid-period.
REQ-019 SHALL latch a sample accepted on the wrap edge into shadow only; it applies at the following wrap, one period later.
REQ-020 SHALL drive pwm_raw high in every cycle with cnt < duty: duty=0 gives constant low, duty=PERIOD gives constant high.
REQ-021 SHALL register pwm_h and pwm_l, with latency of one clock after the cnt value that decides them.
REQ-022 SHALL, while en=0: hold cnt at 0, hold period_start, pwm_h and pwm_l at 0, freeze duty, and keep the handshake and shadow operating.
REQ-023 SHALL restart cnt at 0 on en rising; the first period uses the current duty, or the shadow if pending.

Reset
REQ-024 SHALL, while rst=1, immediately clear cnt, duty, shadow, pending, sat, period_start, pwm_h and pwm_l, and drive ctrl_ready=1; this applies mid-period as well.
REQ-025 SHALL resume at cnt=0 with duty=0 on the first clock after rst deasserts.

Configuration
REQ-026 SHALL support macro PID_PWM_DEADTIME_EN.
REQ-027 With PID_PWM_DEADTIME_EN defined:
- pwm_h = pwm_raw, with each rising edge delayed DT clocks.
- pwm_l = !pwm_raw, with each rising edge delayed DT clocks.
- Both outputs are low during each dead interval.
- A high or low phase shorter than or equal to DT clocks produces no pulse on that output.
- pwm_h and pwm_l are never both 1.
REQ-028 Without PID_PWM_DEADTIME_EN: pwm_h = pwm_raw and pwm_l = !pwm_raw, registered; the DT parameter and dead-time logic are absent.

Verification
REQ-029 Handshake: rst pulse, en=1, send ctrl_data=40 -> after the next wrap, pwm_h is high 40 and low 60 clocks per period; period_start pulses every 100 clocks; sat=0.
REQ-030 Saturation: send -500 -> duty 0, pwm_h constant 0, sat=1; then send 1000 -> duty 100, pwm_h constant 1, sat=1; then send 50 -> sat=0.
REQ-031 Backpressure: send 30 and then 70 within one period -> ctrl_ready=0 after the first accept; the second is accepted only after the wrap; duty becomes 30, then 70 one period later.
REQ-032 Wrap accept: valid 60 presented exactly on the wrap edge -> the current period keeps the old duty, the next keeps the old duty, and 60 appears in the period after that.
REQ-033 Dead-time (macro on, DT=3, duty 40) -> pwm_h high 37 clocks and pwm_l high 57 clocks per period, with 3-clock both-low gaps and no overlap; with duty 2, pwm_h stays 0.
REQ-034 Reset and enable: assert rst at cnt=50 -> all outputs 0 asynchronously, ctrl_ready=1; en=0 for 20 clocks -> no period_start and pwm_h=0; en=1 -> period_start on the next clock.

Source files
------------

// File: rtl/pid_pwm_driver.sv
// PWM back-end for a PID loop: handshake-fed shadow duty, period-aligned duty update, saturation flag.
// Optional complementary dead-time insertion is compiled in with macro PID_PWM_DEADTIME_EN.
module pid_pwm_driver #(
  parameter int CNT_W  = 8,
  parameter int PERIOD = 100
`ifdef PID_PWM_DEADTIME_EN
  ,
  parameter int DT     = 3
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] ctrl_data,
  input  logic        ctrl_valid,
  output logic        ctrl_ready,
  output logic        pwm_h,
  output logic        pwm_l,
  output logic        period_start,
  output logic        sat
);

  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0]  PERIOD_C = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic signed [16:0] PERIOD_S = 17'(PERIOD);

  // Returns {clipped, value} with value limited to 0..PERIOD.
  function automatic logic [CNT_W:0] clip_sample(input logic [15:0] d);
    logic signed [16:0] v;
    v = {d[15], d};
    if (v < 17'sd0) begin
      clip_sample = {1'b1, {CNT_W{1'b0}}};
    end else if (v > PERIOD_S) begin
      clip_sample = {1'b1, PERIOD_C};
    end else begin
      clip_sample = {1'b0, d[CNT_W-1:0]};
    end
  endfunction

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] duty_r;
  logic [CNT_W-1:0] shadow_r;
  logic             pending_r;
  logic             sat_r;
  logic             run_r;
  logic             pwm_h_r;
  logic             pwm_l_r;

  logic             accept_s;
  logic             first_s;
  logic             wrap_s;
  logic             load_s;
  logic [CNT_W-1:0] duty_use_s;
  logic             raw_s;
  logic [CNT_W:0]   clip_s;

  // The first enabled cycle after a stop already runs on a pending shadow value.
  assign accept_s   = ctrl_valid && !pending_r;
  assign first_s    = en && !run_r;
  assign wrap_s     = en && (cnt_r == LAST_C);
  assign load_s     = pending_r && (wrap_s || first_s);
  assign duty_use_s = (first_s && pending_r) ? shadow_r : duty_r;
  assign raw_s      = (cnt_r < duty_use_s);
  assign clip_s     = clip_sample(ctrl_data);

  // Period counter, shadow/active duty registers and input handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= '0;
      duty_r    <= '0;
      shadow_r  <= '0;
      pending_r <= 1'b0;
      sat_r     <= 1'b0;
      run_r     <= 1'b0;
    end else begin
      run_r <= en;
      if (en) begin
        cnt_r <= wrap_s ? '0 : cnt_r + ONE_C;
      end else begin
        cnt_r <= '0;
      end
      if (load_s) begin
        duty_r <= shadow_r;
      end
      if (accept_s) begin
        shadow_r  <= clip_s[CNT_W-1:0];
        sat_r     <= clip_s[CNT_W];
        pending_r <= 1'b1;
      end else if (load_s) begin
        pending_r <= 1'b0;
      end
    end
  end

`ifdef PID_PWM_DEADTIME_EN
  localparam logic [3:0] DT_C = 4'(DT);

  // Saturating run-length counter; only needs to reach DT.
  function automatic logic [3:0] run_inc(input logic [3:0] r);
    if (r >= DT_C) begin
      run_inc = r;
    end else begin
      run_inc = r + 4'd1;
    end
  endfunction

  logic [3:0] hi_run_r;
  logic [3:0] lo_run_r;

  // An output rises only after its phase of pwm_raw has lasted DT previous clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_run_r <= 4'd0;
      lo_run_r <= 4'd0;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else if (!en) begin
      hi_run_r <= 4'd0;
      lo_run_r <= 4'd0;
      pwm_h_r  <= 1'b0;
      pwm_l_r  <= 1'b0;
    end else begin
      pwm_h_r  <= raw_s && (hi_run_r >= DT_C);
      pwm_l_r  <= !raw_s && (lo_run_r >= DT_C);
      hi_run_r <= raw_s ? run_inc(hi_run_r) : 4'd0;
      lo_run_r <= raw_s ? 4'd0 : run_inc(lo_run_r);
    end
  end
`else
  // Complementary outputs registered one clock after the deciding count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_h_r <= 1'b0;
      pwm_l_r <= 1'b0;
    end else if (en) begin
      pwm_h_r <= raw_s;
      pwm_l_r <= !raw_s;
    end else begin
      pwm_h_r <= 1'b0;
      pwm_l_r <= 1'b0;
    end
  end
`endif

  assign ctrl_ready   = !pending_r;
  assign pwm_h        = pwm_h_r;
  assign pwm_l        = pwm_l_r;
  assign sat          = sat_r;
  assign period_start = en && !rst && (cnt_r == '0);

endmodule

// File: tb/tb_pid_pwm_driver.sv
// Scoreboard bench for pid_pwm_driver: a per-cycle reference model queues expected outputs,
// a negedge monitor pops and compares them.
module tb_pid_pwm_driver;
  localparam int PERIOD = 100;
  localparam int DT     = 3;
`ifdef PID_PWM_DEADTIME_EN
  localparam int H40 = 40 - DT;
`else
  localparam int H40 = 40;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] ctrl_data;
  logic        ctrl_valid;
  logic        ctrl_ready;
  logic        pwm_h;
  logic        pwm_l;
  logic        period_start;
  logic        sat;

  pid_pwm_driver dut (
    .clk(clk), .rst(rst), .en(en), .ctrl_data(ctrl_data), .ctrl_valid(ctrl_valid),
    .ctrl_ready(ctrl_ready), .pwm_h(pwm_h), .pwm_l(pwm_l),
    .period_start(period_start), .sat(sat)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic h;
    logic l;
    logic ps;
    logic rdy;
    logic st;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // reference model state: position in period, active duty, pending samples
  int   pos;
  int   duty_m;
  int   pend_q[$];
  bit   sat_m, h_m, l_m, prev_en_m;
  bit   hist_q[$];
  logic cur_rst, cur_en, cur_valid;
  logic [15:0] cur_data;

  function automatic int clip_val(input logic [15:0] d);
    int v;
    v = $signed(d);
    if (v < 0) return 0;
    if (v > PERIOD) return PERIOD;
    return v;
  endfunction

`ifdef PID_PWM_DEADTIME_EN
  function automatic bit held_for_dt(input bit b);
    if (hist_q.size() < DT) return 1'b0;
    for (int i = hist_q.size() - DT; i < hist_q.size(); i++)
      if (hist_q[i] != b) return 1'b0;
    return 1'b1;
  endfunction
`endif

  task automatic model_reset();
    pos = 0; duty_m = 0; pend_q.delete(); sat_m = 0;
    h_m = 0; l_m = 0; prev_en_m = 0; hist_q.delete();
  endtask

  task automatic model_edge();
    bit acc, first, raw;
    int d_eff, c, v;
    if (cur_rst) begin
      model_reset();
    end else begin
      acc = cur_valid && (pend_q.size() == 0);
      if (cur_en) begin
        first = !prev_en_m;
        d_eff = (first && pend_q.size() > 0) ? pend_q[0] : duty_m;
        raw = (pos < d_eff);
        h_m = raw;
        l_m = !raw;
`ifdef PID_PWM_DEADTIME_EN
        h_m = raw && held_for_dt(1'b1);
        l_m = !raw && held_for_dt(1'b0);
        hist_q.push_back(raw);
        if (hist_q.size() > DT) void'(hist_q.pop_front());
`endif
        if ((pos == PERIOD - 1 || first) && pend_q.size() > 0) duty_m = pend_q.pop_front();
        pos = (pos == PERIOD - 1) ? 0 : pos + 1;
      end else begin
        pos = 0; h_m = 0; l_m = 0; hist_q.delete();
      end
      if (acc) begin
        c = clip_val(cur_data);
        v = $signed(cur_data);
        pend_q.push_back(c);
        sat_m = (c != v);
      end
      prev_en_m = cur_en;
    end
  endtask

  task automatic step(input logic e, input logic v, input logic r, input logic [15:0] d);
    exp_t x;
    @(posedge clk);
    model_edge();
    #1;
    cur_en = e; cur_valid = v; cur_rst = r; cur_data = d;
    en = e; ctrl_valid = v; rst = r; ctrl_data = d;
    if (r) model_reset();
    #1;
    if (cur_rst) begin
      x = '{h: 1'b0, l: 1'b0, ps: 1'b0, rdy: 1'b1, st: 1'b0};
    end else begin
      x.h = h_m; x.l = l_m; x.ps = cur_en && (pos == 0);
      x.rdy = (pend_q.size() == 0); x.st = sat_m;
    end
    exp_q.push_back(x);
  endtask

  task automatic chk_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
    end
  endtask

  // holds valid until the model reports the block ready, then lets the accept edge pass
  task automatic send(input int d);
    int n;
    n = 0;
    step(1'b1, 1'b1, 1'b0, 16'(d));
    while (pend_q.size() != 0 && n < 500) begin
      step(1'b1, 1'b1, 1'b0, 16'(d));
      n++;
    end
    if (n >= 500) chk_int("send_timeout", n, 0);
    step(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic measure(input int n, output int hc, output int pc);
    hc = 0; pc = 0;
    repeat (n) begin
      step(1'b1, 1'b0, 1'b0, 16'd0);
      hc += int'(pwm_h);
      pc += int'(period_start);
    end
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic cmp(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
    end
  endtask

  // monitor: pops one expected record per cycle and compares at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("pwm_h", pwm_h, e.h);
        cmp("pwm_l", pwm_l, e.l);
        cmp("period_start", period_start, e.ps);
        cmp("ctrl_ready", ctrl_ready, e.rdy);
        cmp("sat", sat, e.st);
        cmp("no_overlap", pwm_h & pwm_l, 1'b0);
      end
    end
  end

  initial begin
    int hc, pc, n;
    rst = 1'b1; en = 1'b0; ctrl_valid = 1'b0; ctrl_data = 16'd0;
    cur_rst = 1'b1; cur_en = 1'b0; cur_valid = 1'b0; cur_data = 16'd0;
    model_reset();

    repeat (3) step(1'b0, 1'b0, 1'b1, 16'd0);
    run(5);

    // nominal duty 40
    send(40);
    run(2 * PERIOD);
    measure(PERIOD, hc, pc);
    chk_int("duty40_high", hc, H40);
    chk_int("duty40_period_start", pc, 1);

    // saturation both ways, then back in range
    send(-500);
    run(2 * PERIOD);
    measure(PERIOD, hc, pc);
    chk_int("duty_neg_high", hc, 0);
    chk_int("sat_neg", int'(sat), 1);
    send(1000);
    run(2 * PERIOD);
    measure(PERIOD, hc, pc);
    chk_int("duty_big_high", hc, PERIOD);
    chk_int("sat_big", int'(sat), 1);
    send(50);
    chk_int("sat_clear", int'(sat), 0);
    run(2 * PERIOD);

    // backpressure: second sample waits for the wrap
    send(30);
    send(70);
    run(2 * PERIOD);

    // sample presented exactly on the wrap cycle
    n = 0;
    while (!(pos == PERIOD - 1 && pend_q.size() == 0) && n < 3 * PERIOD) begin
      step(1'b1, 1'b0, 1'b0, 16'd0);
      n++;
    end
    if (n >= 3 * PERIOD) chk_int("wrap_wait_timeout", n, 0);
    step(1'b1, 1'b1, 1'b0, 16'd60);
    run(3 * PERIOD);

    // very narrow duty
    send(2);
    run(3 * PERIOD);

    // asynchronous reset mid-period, then a disabled stretch
    n = 0;
    while (pos != 50 && n < 2 * PERIOD) begin
      step(1'b1, 1'b0, 1'b0, 16'd0);
      n++;
    end
    step(1'b1, 1'b0, 1'b1, 16'd0);
    step(1'b0, 1'b0, 1'b1, 16'd0);
    pc = 0; hc = 0;
    repeat (20) begin
      step(1'b0, 1'b0, 1'b0, 16'd0);
      pc += int'(period_start);
      hc += int'(pwm_h);
    end
    chk_int("disabled_period_start", pc, 0);
    chk_int("disabled_pwm_h", hc, 0);
    step(1'b1, 1'b0, 1'b0, 16'd0);
    chk_int("enable_period_start", int'(period_start), 1);
    run(PERIOD);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic e, v, r;
      logic [15:0] d;
      e = ($urandom_range(0, 99) < 97);
      v = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 3) == 0) d = 16'($urandom);
      else d = 16'(int'($urandom_range(0, 110)) - 5);
      step(e, v, r, d);
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
